// File: rtl/ntt_bf_scheduler_if.sv
// Butterfly issue / write-back bus between the NTT scheduler and its datapath.
// Master drives reads and write-backs, slave drives backpressure.
interface ntt_bf_scheduler_if #(
    parameter int LOG_N = 8
);
    logic               bf_stall;
    logic               rd_en;
    logic [LOG_N-1:0]   rd_addr_a;
    logic [LOG_N-1:0]   rd_addr_b;
    logic [LOG_N-2:0]   tw_idx;
    logic               inv;
    logic               wr_en;
    logic [LOG_N-1:0]   wr_addr_a;
    logic [LOG_N-1:0]   wr_addr_b;

    modport master (
        input  bf_stall,
        output rd_en, rd_addr_a, rd_addr_b, tw_idx, inv,
        output wr_en, wr_addr_a, wr_addr_b
    );

    modport slave (
        output bf_stall,
        input  rd_en, rd_addr_a, rd_addr_b, tw_idx, inv,
        input  wr_en, wr_addr_a, wr_addr_b
    );
endinterface

// File: rtl/ntt_bf_scheduler.sv
// In-place radix-2 NTT butterfly sequencer with write-back delay line.
// Define NTT_INVERSE_EN to enable inverse (GS) sequencing via mode.
module ntt_bf_scheduler #(
    parameter int LOG_N  = 8,
    parameter int BF_LAT = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                mode,
    output logic                busy,
    output logic                done,
    output logic [2:0]          layer,
    ntt_bf_scheduler_if.master  bif
);
    localparam int HALF = 1 << (LOG_N - 1);
    localparam int DW   = $clog2(BF_LAT + 1);

    typedef logic [LOG_N-1:0] addr_t;
    typedef logic [LOG_N-2:0] idx_t;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t          state;
    idx_t            bcnt;
    logic [DW-1:0]   dcnt;
    logic            inv_q;
    logic            rd_v;
    addr_t           rd_a;
    addr_t           rd_b;
    idx_t            tw_q;
    logic            dl_v [BF_LAT];
    addr_t           dl_a [BF_LAT];
    addr_t           dl_b [BF_LAT];

    logic            mode_eff;
    logic [2:0]      g_layer;
    idx_t            g_bcnt;
    logic            g_inv;
    int unsigned     lg;
    addr_t           len;
    idx_t            grp;
    idx_t            groups;
    addr_t           g_a;
    addr_t           g_b;
    idx_t            g_tw;

`ifdef NTT_INVERSE_EN
    assign mode_eff = mode;
`else
    assign mode_eff = mode & 1'b0;
`endif

    // Butterfly that will be presented next cycle.
    always_comb begin
        g_layer = layer;
        g_bcnt  = bcnt + idx_t'(1);
        g_inv   = inv_q;
        case (state)
            IDLE: begin
                g_layer = 3'd0;
                g_bcnt  = '0;
                g_inv   = mode_eff;
            end
            DRAIN: begin
                g_layer = layer + 3'd1;
                g_bcnt  = '0;
            end
            default: ;
        endcase
    end

    always_comb begin
        lg = g_inv ? (32'(g_layer) + 32'd1)
                   : (32'(LOG_N - 1) - 32'(g_layer));
        len    = addr_t'(1) << lg;
        grp    = g_bcnt >> lg;
        groups = idx_t'(1) << (32'(LOG_N - 1) - lg);
        g_a    = (addr_t'(grp) << (lg + 32'd1))
               | (addr_t'(g_bcnt) & (len - addr_t'(1)));
        g_b    = g_a + len;
        g_tw   = groups + grp;
`ifdef NTT_INVERSE_EN
        if (g_inv)
            g_tw = (groups << 1) - idx_t'(1) - grp;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            layer <= '0;
            bcnt  <= '0;
            dcnt  <= '0;
            inv_q <= 1'b0;
            rd_v  <= 1'b0;
            rd_a  <= '0;
            rd_b  <= '0;
            tw_q  <= '0;
            for (int i = 0; i < BF_LAT; i++) begin
                dl_v[i] <= 1'b0;
                dl_a[i] <= '0;
                dl_b[i] <= '0;
            end
        end else if (!bif.bf_stall) begin
            dl_v[0] <= rd_v;
            dl_a[0] <= rd_a;
            dl_b[0] <= rd_b;
            for (int i = 1; i < BF_LAT; i++) begin
                dl_v[i] <= dl_v[i-1];
                dl_a[i] <= dl_a[i-1];
                dl_b[i] <= dl_b[i-1];
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= ISSUE;
                        layer <= '0;
                        bcnt  <= '0;
                        inv_q <= mode_eff;
                        rd_v  <= 1'b1;
                        rd_a  <= g_a;
                        rd_b  <= g_b;
                        tw_q  <= g_tw;
                    end
                end
                ISSUE: begin
                    if (bcnt == idx_t'(HALF - 1)) begin
                        state <= DRAIN;
                        dcnt  <= '0;
                        rd_v  <= 1'b0;
                    end else begin
                        bcnt <= g_bcnt;
                        rd_a <= g_a;
                        rd_b <= g_b;
                        tw_q <= g_tw;
                    end
                end
                DRAIN: begin
                    if (dcnt == DW'(BF_LAT - 1)) begin
                        if (layer == 3'(LOG_N - 2)) begin
                            state <= DONE;
                        end else begin
                            state <= ISSUE;
                            layer <= g_layer;
                            bcnt  <= '0;
                            rd_v  <= 1'b1;
                            rd_a  <= g_a;
                            rd_b  <= g_b;
                            tw_q  <= g_tw;
                        end
                    end else begin
                        dcnt <= dcnt + DW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A stalled slot is held, not consumed.
    assign bif.rd_en     = rd_v & ~bif.bf_stall;
    assign bif.rd_addr_a = rd_a;
    assign bif.rd_addr_b = rd_b;
    assign bif.tw_idx    = tw_q;
    assign bif.inv       = inv_q;
    assign bif.wr_en     = dl_v[BF_LAT-1] & ~bif.bf_stall;
    assign bif.wr_addr_a = dl_a[BF_LAT-1];
    assign bif.wr_addr_b = dl_b[BF_LAT-1];

    assign busy = (state != IDLE);
    assign done = (state == DONE);
endmodule

// File: tb/tb_ntt_bf_scheduler.sv
// Directed bench for ntt_bf_scheduler: address/twiddle vectors, drain,
// stall, mid-run reset and start-while-busy against a loop-nest model.
module tb_ntt_bf_scheduler;
    localparam int LOG_N  = 8;
    localparam int BF_LAT = 4;
    localparam int NB     = 896;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       mode = 1'b0;
    logic       busy;
    logic       done;
    logic [2:0] layer;

    ntt_bf_scheduler_if #(.LOG_N(LOG_N)) bif ();

    ntt_bf_scheduler #(
        .LOG_N (LOG_N),
        .BF_LAT(BF_LAT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .mode (mode),
        .busy (busy),
        .done (done),
        .layer(layer),
        .bif  (bif)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int t0 = 0;
    int n_pass = 0;
    int n_chk = 0;

    bit mon = 1'b0;
    int rel;
    int n_rd, n_wr, sb_err;
    int done_rel, idle_rel;
    int n_stall, stall_rd, stall_wr, hold_err;
    int fw_rel, fw_a, fw_b;
    int first_rd [7];
    int last_wr [7];
    int rd_a [NB];
    int rd_b [NB];
    int rd_tw [NB];
    int rd_rel [NB];
    int q [$];

    task automatic chk(string tag, int got, int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic clear();
        n_rd = 0; n_wr = 0; sb_err = 0;
        done_rel = -1; idle_rel = -1;
        n_stall = 0; stall_rd = 0; stall_wr = 0; hold_err = 0;
        fw_rel = -1; fw_a = -1; fw_b = -1;
        q.delete();
        for (int i = 0; i < 7; i++) begin
            first_rd[i] = -1;
            last_wr[i] = -1;
        end
    endtask

    always @(negedge clk) begin
        if (mon) begin
            rel = cyc - t0;
            if (bif.bf_stall) begin
                n_stall++;
                if (bif.rd_en) stall_rd++;
                if (bif.wr_en) stall_wr++;
                if (bif.rd_addr_a != 10 || bif.rd_addr_b != 138)
                    hold_err++;
            end
            if (bif.rd_en) begin
                if (n_rd < NB) begin
                    rd_a[n_rd] = int'(bif.rd_addr_a);
                    rd_b[n_rd] = int'(bif.rd_addr_b);
                    rd_tw[n_rd] = int'(bif.tw_idx);
                    rd_rel[n_rd] = rel;
                    if (n_rd % 128 == 0) first_rd[n_rd/128] = rel;
                end
                q.push_back(int'(bif.rd_addr_a) * 256 + int'(bif.rd_addr_b));
                n_rd++;
            end
            if (bif.wr_en) begin
                if (n_wr == 0) begin
                    fw_rel = rel;
                    fw_a = int'(bif.wr_addr_a);
                    fw_b = int'(bif.wr_addr_b);
                end
                if (q.size() == 0) sb_err++;
                else if (q.pop_front() !=
                         int'(bif.wr_addr_a) * 256 + int'(bif.wr_addr_b))
                    sb_err++;
                if (n_wr < NB) last_wr[n_wr/128] = rel;
                n_wr++;
            end
            if (done && done_rel < 0) done_rel = rel;
            if (!busy && done_rel >= 0 && idle_rel < 0) idle_rel = rel;
        end
    end

    task automatic go(bit m);
        @(posedge clk);
        #1;
        clear();
        mode = m;
        start = 1'b1;
        t0 = cyc;
        mon = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        mode = ~m;
    endtask

    task automatic wait_rel(int r);
        while (cyc - t0 < r) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_done(string tag);
        for (int i = 0; i < 1500 && idle_rel < 0; i++) @(posedge clk);
        #1;
        chk({tag, ".finish"}, int'(idle_rel >= 0), 1);
    endtask

    // Textbook NTT loop nest; twiddle counter runs up (fwd) or down (inv).
    task automatic model(string tag, bit inv);
        int idx = 0;
        int err = 0;
        int k = inv ? 127 : 1;
        int len = inv ? 2 : 128;
        for (int l = 0; l < 7; l++) begin
            for (int s = 0; s < 256; s += 2 * len) begin
                for (int j = s; j < s + len; j++) begin
                    if (rd_a[idx] != j || rd_b[idx] != j + len ||
                        rd_tw[idx] != k) err++;
                    idx++;
                end
                k = inv ? k - 1 : k + 1;
            end
            len = inv ? len * 2 : len / 2;
        end
        chk({tag, ".model"}, err, 0);
    endtask

    task automatic totals(string tag, int done_exp);
        chk({tag, ".done"}, done_rel, done_exp);
        chk({tag, ".idle"}, idle_rel, done_exp + 1);
        chk({tag, ".n_rd"}, n_rd, NB);
        chk({tag, ".n_wr"}, n_wr, NB);
        chk({tag, ".sb"}, sb_err, 0);
    endtask

    int wr0;

    initial begin
        bif.bf_stall = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.busy", int'(busy), 0);
        chk("rst.done", int'(done), 0);
        chk("rst.rd_en", int'(bif.rd_en), 0);
        chk("rst.wr_en", int'(bif.wr_en), 0);
        chk("rst.layer", int'(layer), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Forward run with a start pulse while busy.
        go(1'b0);
        wait_rel(50);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("fwd");
        chk("fwd.rd0_rel", rd_rel[0], 1);
        chk("fwd.rd0_a", rd_a[0], 0);
        chk("fwd.rd0_b", rd_b[0], 128);
        chk("fwd.rd0_tw", rd_tw[0], 1);
        chk("fwd.wr0_rel", fw_rel, 5);
        chk("fwd.wr0_a", fw_a, 0);
        chk("fwd.wr0_b", fw_b, 128);
        chk("fwd.l1b64_a", rd_a[192], 128);
        chk("fwd.l1b64_b", rd_b[192], 192);
        chk("fwd.l1b64_tw", rd_tw[192], 3);
        chk("fwd.l6b127_a", rd_a[895], 253);
        chk("fwd.l6b127_b", rd_b[895], 255);
        chk("fwd.l6b127_tw", rd_tw[895], 127);
        for (int l = 0; l < 6; l++)
            chk($sformatf("fwd.gap%0d", l), first_rd[l+1] - last_wr[l], 1);
        chk("fwd.last_wr", last_wr[6], 924);
        totals("fwd", 925);
        model("fwd", 1'b0);

        // mode=1 at start.
        go(1'b1);
        wait_done("m1");
`ifdef NTT_INVERSE_EN
        chk("inv.b0_a", rd_a[0], 0);
        chk("inv.b0_b", rd_b[0], 2);
        chk("inv.b0_tw", rd_tw[0], 127);
        chk("inv.b1_a", rd_a[1], 1);
        chk("inv.b1_b", rd_b[1], 3);
        chk("inv.b1_tw", rd_tw[1], 127);
        chk("inv.b2_a", rd_a[2], 4);
        chk("inv.b2_b", rd_b[2], 6);
        chk("inv.b2_tw", rd_tw[2], 126);
        chk("inv.l6_a", rd_a[768], 0);
        chk("inv.l6_b", rd_b[768], 128);
        chk("inv.l6_tw", rd_tw[768], 1);
        model("inv", 1'b1);
`else
        chk("m1.b0_b", rd_b[0], 128);
        chk("m1.b0_tw", rd_tw[0], 1);
        model("m1", 1'b0);
`endif
        totals("m1", 925);

        // Three-cycle stall while bcnt 10 is presented.
        go(1'b0);
        wait_rel(11);
        bif.bf_stall = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bif.bf_stall = 1'b0;
        wait_done("stall");
        chk("stall.cycles", n_stall, 3);
        chk("stall.rd_en", stall_rd, 0);
        chk("stall.wr_en", stall_wr, 0);
        chk("stall.hold", hold_err, 0);
        chk("stall.b10_rel", rd_rel[10], 14);
        chk("stall.b10_a", rd_a[10], 10);
        totals("stall", 928);
        model("stall", 1'b0);

        // Reset mid-transform.
        go(1'b0);
        wait_rel(300);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        wr0 = n_wr;
        @(negedge clk);
        chk("mrst.busy", int'(busy), 0);
        chk("mrst.done", int'(done), 0);
        chk("mrst.layer", int'(layer), 0);
        chk("mrst.rd_en", int'(bif.rd_en), 0);
        chk("mrst.rd_a", int'(bif.rd_addr_a), 0);
        chk("mrst.rd_b", int'(bif.rd_addr_b), 0);
        chk("mrst.tw", int'(bif.tw_idx), 0);
        chk("mrst.inv", int'(bif.inv), 0);
        chk("mrst.wr_en", int'(bif.wr_en), 0);
        chk("mrst.wr_a", int'(bif.wr_addr_a), 0);
        chk("mrst.wr_b", int'(bif.wr_addr_b), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("mrst.no_wr", n_wr - wr0, 0);
        chk("mrst.idle", int'(busy), 0);

        go(1'b0);
        wait_done("post");
        totals("post", 925);
        model("post", 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
